waveform_player: RTL and testbench
==================================

Name: waveform_player

Overview:
- Initiator and reader for the waveform converter's start/ready/array interface.
- On request, latches a one-hot waveform select and pulses start to the converter, then waits for ready and snapshots the 256-sample output array into a local buffer.
- Plays the buffer out one sample at a time over a valid/ready stream toward the DAC/filter path.
- Playback rate is set by a phase-accumulator tuning word.

Parameters:
- DEPTH, 256, samples per waveform; power of two.
- DW, 8, sample width.
- PW, 16, phase accumulator width; address = acc[PW-1 -: log2(DEPTH)].
- SETTLE, 2, minimum cycles in WAIT before conv_rdy_flg is trusted.
- TIMEOUT, 16, WAIT cycles before abort.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  level; request (re)load of waveform selected by sel.
- sel  in  4  one-hot select passed to converter (0001 sine, 0010 tri, 0100 square, 1000 FM).
- ftw  in  PW  phase increment per accepted sample.
- enable  in  1  playback enable.
- conv_sw  out  4  select driven to converter, latched at START.
- conv_start_flg  out  1  one-cycle start pulse to converter.
- conv_rdy_flg  in  1  converter ready; sticky high once set.
- conv_wave  in  DW x DEPTH  converter output array.
- m_valid  out  1  stream valid.
- m_data  out  DW  stream sample.
- m_ready  in  1  downstream ready.
- busy  out  1  high in START/WAIT/CAPTURE.
- err  out  1  sticky timeout flag, cleared on next START.

Behaviour:
- Reset values, asynchronous on rst_n low: state IDLE, conv_sw 0, conv_start_flg 0, m_valid 0, m_data 0, busy 0, err 0, acc 0, all buffer entries 0, req_pend 0.
- IDLE:
  - req=1 -> START.
  - enable=1 and buffer loaded once since reset -> PLAY.
- START:
  - One cycle; conv_start_flg=1, conv_sw<=sel, err<=0, wait counter cleared -> WAIT.
- WAIT:
  - Counter increments each cycle.
  - conv_rdy_flg is ignored until count>=SETTLE, because it may still be high from a previous load.
  - count>=SETTLE and conv_rdy_flg=1 -> CAPTURE.
  - count reaches TIMEOUT -> err<=1, IDLE; buffer unchanged.
- CAPTURE:
  - One cycle; all DEPTH entries copied from conv_wave in parallel.
  - acc<=0, loaded<=1 -> PLAY.
- PLAY:
  - If m_valid=0 and enable=1: m_data<=buf[addr(acc)], m_valid<=1.
  - Handshake (m_valid & m_ready): acc<=acc+ftw (mod 2^PW). m_data<=buf[addr(acc+ftw)] and m_valid stays 1 if enable=1 and req_pend=0; else m_valid<=0.
  - m_valid & !m_ready: m_valid and m_data held stable regardless of enable, req, or ftw change.
  - req in PLAY sets req_pend. Transition PLAY -> START happens when m_valid=0, or on the handshake cycle. req_pend is cleared on entering START.
  - enable=0 with m_valid=0 -> IDLE; acc retained.
- Address wrap: acc overflow wraps naturally, so sample DEPTH-1 is followed by sample 0.
- ftw=0: the same sample repeats every handshake.
- Latency:
  - req to conv_start_flg: 1 cycle.
  - CAPTURE to first m_valid: 1 cycle.
- busy=1 exactly in START, WAIT and CAPTURE.
- req held high continuously restarts a load after each CAPTURE+PLAY entry. This is legal; callers pulse req.
- Reset mid-WAIT: converter outputs may be stale. On next load the SETTLE rule still applies.

Decomposition:
- waveform_pkg:
  - DEPTH, DW, one-hot select constants SEL_SINE/SEL_TRI/SEL_SQUARE/SEL_FM.
  - state enum {IDLE, START, WAIT, CAPTURE, PLAY}.
  - sample_t typedef.
- Sub-module phase_accumulator (PW): clear, advance strobe, ftw in; acc and next-acc out.

Test Plan:
- Reset: assert rst_n=0 mid-PLAY with m_valid=1 -> m_valid=0, m_data=0, busy=0, err=0 immediately, without waiting for a clk edge.
- Load and unit step: conv_wave[i]=i, req pulse, conv_rdy_flg rises 1 cycle after start, ftw=0x0100, m_ready=1 -> conv_start_flg single pulse, conv_sw=sel, m_data sequence 0,1,2,...,255,0,1.
- Rate: ftw=0x0280, m_ready=1 -> m_data 0,2,5,7,10; after 256 beats acc wraps to 0x8000.
- Backpressure: m_ready low 5 cycles with m_data=3 -> m_valid=1 and m_data=3 held all 5 cycles; next beat is 4; toggle enable=0 during the stall -> no effect until the handshake.
- Timeout and stale ready: conv_rdy_flg stuck 0 -> err=1 after 16 WAIT cycles, state IDLE. Separately, conv_rdy_flg stuck 1 -> capture occurs no earlier than the 2nd WAIT cycle.
- Reload mid-play: req during a stalled beat -> START only after that beat handshakes; new buffer plays from address 0 and err is cleared.

Source files
------------

// File: rtl/waveform_pkg.sv
// Shared constants, select encodings and FSM state type for the waveform player.
package waveform_pkg;

  localparam int unsigned DEPTH   = 256;
  localparam int unsigned DW      = 8;
  localparam int unsigned PW      = 16;
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned SETTLE  = 2;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CW      = $clog2(TIMEOUT + 1);

  localparam logic [3:0] SEL_SINE   = 4'b0001;
  localparam logic [3:0] SEL_TRI    = 4'b0010;
  localparam logic [3:0] SEL_SQUARE = 4'b0100;
  localparam logic [3:0] SEL_FM     = 4'b1000;

  typedef logic [DW-1:0] sample_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    CAPTURE,
    PLAY
  } state_t;

endpackage

// File: rtl/phase_accumulator.sv
// Phase accumulator: clears to zero, advances by ftw on each strobe.
module phase_accumulator #(
  parameter int unsigned PW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          advance,
  input  logic [PW-1:0] ftw,
  output logic [PW-1:0] acc,
  output logic [PW-1:0] acc_next_c
);

  // Wraps modulo 2^PW so the top address bits roll from DEPTH-1 back to 0.
  assign acc_next_c = acc + ftw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (advance) begin
      acc <= acc_next_c;
    end
  end

endmodule

// File: rtl/waveform_player.sv
// Starts the waveform converter, snapshots its output array and streams it
// out at a rate set by a phase-accumulator tuning word.
module waveform_player
  import waveform_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req,
  input  logic [3:0]              sel,
  input  logic [PW-1:0]           ftw,
  input  logic                    enable,
  output logic [3:0]              conv_sw,
  output logic                    conv_start_flg,
  input  logic                    conv_rdy_flg,
  input  sample_t [DEPTH-1:0]     conv_wave,
  output logic                    m_valid,
  output sample_t                 m_data,
  input  logic                    m_ready,
  output logic                    busy,
  output logic                    err
);

  state_t               state_q;
  state_t               state_d;
  logic [CW-1:0]        cnt_q;
  logic                 loaded_q;
  logic                 req_pend_q;
  sample_t [DEPTH-1:0]  wave_buf;
  logic [PW-1:0]        acc;
  logic [PW-1:0]        acc_next_c;
  logic [AW-1:0]        addr_c;
  logic [AW-1:0]        addr_next_c;
  logic                 hs_c;
  logic                 reload_c;
  logic                 launch_c;
  logic                 keep_c;
  logic                 timeout_c;

  assign hs_c        = (state_q == PLAY) && m_valid && m_ready;
  assign reload_c    = req || req_pend_q;
  assign addr_c      = acc[PW-1 -: AW];
  assign addr_next_c = acc_next_c[PW-1 -: AW];

  phase_accumulator #(
    .PW(PW)
  ) u_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (state_q == CAPTURE),
    .advance    (hs_c),
    .ftw        (ftw),
    .acc        (acc),
    .acc_next_c (acc_next_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus per-cycle strobes for the datapath.
  always_comb begin
    state_d   = state_q;
    launch_c  = 1'b0;
    keep_c    = 1'b0;
    timeout_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = START;
        end else if (enable && loaded_q) begin
          state_d = PLAY;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        // Ready may still be high from the previous load until SETTLE cycles pass.
        if ((cnt_q >= CW'(SETTLE)) && conv_rdy_flg) begin
          state_d = CAPTURE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d   = IDLE;
          timeout_c = 1'b1;
        end
      end
      CAPTURE: state_d = PLAY;
      PLAY: begin
        if (m_valid) begin
          if (m_ready) begin
            if (reload_c) begin
              state_d = START;
            end else if (enable) begin
              keep_c = 1'b1;
            end
          end
        end else if (reload_c) begin
          state_d = START;
        end else if (enable) begin
          launch_c = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Converter handshake, status and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_sw        <= '0;
      conv_start_flg <= 1'b0;
      busy           <= 1'b0;
      err            <= 1'b0;
      cnt_q          <= '0;
      loaded_q       <= 1'b0;
      req_pend_q     <= 1'b0;
    end else begin
      conv_start_flg <= (state_d == START);
      busy           <= (state_d == START) || (state_d == WAIT) || (state_d == CAPTURE);
      if (state_d == START) begin
        conv_sw <= sel;
      end
      if (state_q == START) begin
        cnt_q <= '0;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (state_q == START) begin
        err <= 1'b0;
      end else if (timeout_c) begin
        err <= 1'b1;
      end
      if (state_q == CAPTURE) begin
        loaded_q <= 1'b1;
      end
      if (state_d == START) begin
        req_pend_q <= 1'b0;
      end else if ((state_q == PLAY) && req) begin
        req_pend_q <= 1'b1;
      end
    end
  end

  // Sample buffer and output stream; a stalled beat holds until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wave_buf <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
    end else begin
      if (state_q == CAPTURE) begin
        wave_buf <= conv_wave;
        m_valid  <= enable;
        m_data   <= conv_wave[0];
      end else if (launch_c) begin
        m_valid <= 1'b1;
        m_data  <= wave_buf[addr_c];
      end else if (hs_c) begin
        m_valid <= keep_c;
        if (keep_c) begin
          m_data <= wave_buf[addr_next_c];
        end
      end
    end
  end

endmodule

// File: tb/tb_waveform_player.sv
// Directed bench for waveform_player: load, rate, backpressure, timeout, reload, reset.
module tb_waveform_player;
  import waveform_pkg::*;

  logic                clk;
  logic                rst_n;
  logic                req;
  logic [3:0]          sel;
  logic [PW-1:0]       ftw;
  logic                enable;
  logic [3:0]          conv_sw;
  logic                conv_start_flg;
  logic                conv_rdy_flg;
  sample_t [DEPTH-1:0] conv_wave;
  logic                m_valid;
  sample_t             m_data;
  logic                m_ready;
  logic                busy;
  logic                err;

  int checks = 0;
  int errors = 0;
  int n;
  int rate_exp [5] = '{0, 2, 5, 7, 10};

  waveform_player dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .sel            (sel),
    .ftw            (ftw),
    .enable         (enable),
    .conv_sw        (conv_sw),
    .conv_start_flg (conv_start_flg),
    .conv_rdy_flg   (conv_rdy_flg),
    .conv_wave      (conv_wave),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_ready        (m_ready),
    .busy           (busy),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with busy high (bounded), then expects a valid beat.
  task automatic count_busy(input string tag, output int cyc);
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      tick();
    end
    if (!m_valid) tick();
    check({tag, "_valid"}, 32'(m_valid), 32'd1);
  endtask

  initial begin
    rst_n        = 1'b0;
    req          = 1'b0;
    sel          = '0;
    ftw          = '0;
    enable       = 1'b0;
    m_ready      = 1'b0;
    conv_rdy_flg = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) conv_wave[i] = 8'(i);
    #2;
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_sw", 32'(conv_sw), 32'd0);
    check("rst_start", 32'(conv_start_flg), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Load with unit step
    sel = SEL_TRI; ftw = 16'h0100; enable = 1'b1; m_ready = 1'b1; req = 1'b1;
    tick();
    req = 1'b0;
    check("load_start", 32'(conv_start_flg), 32'd1);
    check("load_sw", 32'(conv_sw), 32'h2);
    check("load_busy", 32'(busy), 32'd1);
    tick();
    check("load_start_pulse", 32'(conv_start_flg), 32'd0);
    conv_rdy_flg = 1'b1;
    count_busy("load", n);
    for (int k = 0; k < 258; k++) begin
      check("unit_seq", 32'(m_data), 32'(k % 256));
      tick();
    end

    // Rate with stale ready still high
    sel = SEL_SQUARE; ftw = 16'h0280; req = 1'b1;
    tick();
    req = 1'b0;
    check("rate_start", 32'(conv_start_flg), 32'd1);
    check("rate_sw", 32'(conv_sw), 32'h4);
    check("rate_valid_drop", 32'(m_valid), 32'd0);
    count_busy("rate", n);
    check("stale_rdy_busy_cycles", 32'(n), 32'd5);
    for (int k = 0; k < 256; k++) begin
      if (k < 5) check("rate_seq", 32'(m_data), 32'(rate_exp[k]));
      tick();
    end
    check("rate_wrap", 32'(m_data), 32'h80);

    // Backpressure
    sel = SEL_SINE; ftw = 16'h0100; req = 1'b1;
    tick();
    req = 1'b0;
    count_busy("bp", n);
    check("bp_first", 32'(m_data), 32'd0);
    tick(); tick(); tick();
    check("bp_pre", 32'(m_data), 32'd3);
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      enable = (i >= 1 && i <= 3) ? 1'b0 : 1'b1;
      tick();
      check("bp_hold_valid", 32'(m_valid), 32'd1);
      check("bp_hold_data", 32'(m_data), 32'd3);
    end
    enable = 1'b1;
    m_ready = 1'b1;
    tick();
    check("bp_next_valid", 32'(m_valid), 32'd1);
    check("bp_next_data", 32'(m_data), 32'd4);

    // Timeout: ready stuck low
    conv_rdy_flg = 1'b0; enable = 1'b0; req = 1'b1;
    tick();
    req = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    check("timeout_busy_cycles", 32'(n), 32'd17);
    check("timeout_err", 32'(err), 32'd1);
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_valid", 32'(m_valid), 32'd0);

    // Buffer must be unchanged after timeout; acc retained at 0x0500
    for (int i = 0; i < int'(DEPTH); i++) conv_wave[i] = 8'(255 - i);
    m_ready = 1'b0; enable = 1'b1;
    n = 0;
    while (!m_valid && n < 10) begin
      n++;
      tick();
    end
    check("resume_valid", 32'(m_valid), 32'd1);
    check("resume_data", 32'(m_data), 32'd5);

    // Reload during a stalled beat
    conv_rdy_flg = 1'b1; req = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("reload_hold_valid", 32'(m_valid), 32'd1);
      check("reload_hold_data", 32'(m_data), 32'd5);
      check("reload_hold_busy", 32'(busy), 32'd0);
      tick();
    end
    m_ready = 1'b1;
    tick();
    check("reload_start", 32'(conv_start_flg), 32'd1);
    check("reload_valid_drop", 32'(m_valid), 32'd0);
    count_busy("reload", n);
    check("reload_data0", 32'(m_data), 32'd255);
    check("reload_err_clr", 32'(err), 32'd0);
    tick();
    check("reload_data1", 32'(m_data), 32'd254);

    // Asynchronous reset mid-play
    check("pre_rst_valid", 32'(m_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(m_valid), 32'd0);
    check("async_rst_data", 32'(m_data), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_err", 32'(err), 32'd0);
    check("async_rst_sw", 32'(conv_sw), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
